// File: rtl/mem_copy_engine_pkg.sv
// Shared definitions for the memory copy engine: FSM state encoding and word geometry.
package mem_copy_engine_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRead  = 2'd1,
        StWrite = 2'd2,
        StDone  = 2'd3
    } state_e;

    localparam logic [31:0] WORD_BYTES = 32'd4;

    // Word-aligns a byte address by clearing the two byte-offset bits.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return addr & ~32'h3;
    endfunction

endpackage

// File: rtl/mem_copy_checksum.sv
// Running 32-bit additive checksum over the words written by the copy engine.
module mem_copy_checksum
    import mem_copy_engine_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        enable,
    input  logic [31:0] data,
    output logic [31:0] sum
);

    logic [31:0] sum_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q <= '0;
        end else if (clear) begin
            sum_q <= '0;
        end else if (enable) begin
            sum_q <= sum_q + data;
        end
    end

    assign sum = sum_q;

endmodule

// File: rtl/mem_copy_engine.sv
// Block copy engine driving the single-port data memory: one READ then one WRITE cycle per word.
// Optional checksum output and accumulator are built when MEM_COPY_CHECKSUM_EN is defined.
module mem_copy_engine
    import mem_copy_engine_pkg::*;
#(
    parameter int unsigned LEN_W = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             mem_write,
    output logic [31:0]      mem_address,
    output logic [31:0]      mem_write_data,
    input  logic [31:0]      mem_read_data
`ifdef MEM_COPY_CHECKSUM_EN
    ,
    output logic [31:0]      checksum
`endif
);

    state_e           state_q, state_d;
    logic [31:0]      src_ptr_q, src_ptr_d;
    logic [31:0]      dst_ptr_q, dst_ptr_d;
    logic [LEN_W-1:0] remaining_q, remaining_d;
    logic [31:0]      data_buf_q, data_buf_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            src_ptr_q   <= '0;
            dst_ptr_q   <= '0;
            remaining_q <= '0;
            data_buf_q  <= '0;
        end else begin
            state_q     <= state_d;
            src_ptr_q   <= src_ptr_d;
            dst_ptr_q   <= dst_ptr_d;
            remaining_q <= remaining_d;
            data_buf_q  <= data_buf_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        src_ptr_d      = src_ptr_q;
        dst_ptr_d      = dst_ptr_q;
        remaining_d    = remaining_q;
        data_buf_d     = data_buf_q;
        busy           = 1'b0;
        done           = 1'b0;
        mem_write      = 1'b0;
        mem_address    = '0;
        mem_write_data = '0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    src_ptr_d   = align_word(src_addr);
                    dst_ptr_d   = align_word(dst_addr);
                    remaining_d = len;
                    state_d     = (len == '0) ? StDone : StRead;
                end
            end
            StRead: begin
                busy        = 1'b1;
                mem_address = src_ptr_q;
                data_buf_d  = mem_read_data;
                state_d     = StWrite;
            end
            StWrite: begin
                busy           = 1'b1;
                mem_write      = 1'b1;
                mem_address    = dst_ptr_q;
                mem_write_data = data_buf_q;
                // Pointers wrap modulo 2^32 through plain 32-bit addition.
                src_ptr_d      = src_ptr_q + WORD_BYTES;
                dst_ptr_d      = dst_ptr_q + WORD_BYTES;
                remaining_d    = remaining_q - LEN_W'(1);
                state_d        = (remaining_q == LEN_W'(1)) ? StDone : StRead;
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

`ifdef MEM_COPY_CHECKSUM_EN
    mem_copy_checksum u_checksum (
        .clk    (clk),
        .reset  (reset),
        .clear  ((state_q == StIdle) && start),
        .enable (state_q == StWrite),
        .data   (data_buf_q),
        .sum    (checksum)
    );
`endif

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench for mem_copy_engine with a word memory model and a write scoreboard.
module tb_mem_copy_engine;

    localparam int LEN_W = 11;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [31:0]      src_addr;
    logic [31:0]      dst_addr;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             done;
    logic             mem_write;
    logic [31:0]      mem_address;
    logic [31:0]      mem_write_data;
    logic [31:0]      mem_read_data;
`ifdef MEM_COPY_CHECKSUM_EN
    logic [31:0]      checksum;
`endif

    logic [31:0] mem   [0:1023];
    logic [31:0] model [0:1023];
    logic        pre_we;
    logic [9:0]  pre_idx;
    logic [31:0] pre_data;

    wr_t         exp_q[$];
    wr_t         mon_e;
    logic [31:0] exp_sum;
    int          errors = 0;
    int          checks = 0;

    mem_copy_engine #(.LEN_W(LEN_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .src_addr       (src_addr),
        .dst_addr       (dst_addr),
        .len            (len),
        .busy           (busy),
        .done           (done),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
`ifdef MEM_COPY_CHECKSUM_EN
        ,
        .checksum       (checksum)
`endif
    );

    always #5 clk = ~clk;

    assign mem_read_data = mem[mem_address[11:2]];

    always @(posedge clk) begin
        if (pre_we) mem[pre_idx] = pre_data;
        else if (mem_write === 1'b1) mem[mem_address[11:2]] = mem_write_data;
    end

    // Every cycle: address alignment, and each write strobe against the scoreboard.
    always @(negedge clk) begin
        checks++;
        if (mem_address[1:0] !== 2'b00) begin
            errors++;
            $display("FAIL align: mem_address=%h, low bits must be 00", mem_address);
        end
        if (mem_write === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr=%h data=%h, no write expected",
                         mem_address, mem_write_data);
            end else begin
                mon_e = exp_q.pop_front();
                if ({mem_address, mem_write_data} !== mon_e) begin
                    errors++;
                    $display("FAIL write: got addr=%h data=%h, expected addr=%h data=%h",
                             mem_address, mem_write_data, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    task automatic preload(input int idx, input logic [31:0] v);
        @(negedge clk);
        pre_we = 1'b1; pre_idx = 10'(idx); pre_data = v;
        @(posedge clk);
        #1 pre_we = 1'b0;
        model[idx] = v;
    endtask

    // Forward word-by-word copy on the model; expected writes go to the scoreboard.
    task automatic push_copy(input logic [31:0] src, input logic [31:0] dst, input int n);
        logic [31:0] sa, da;
        sa = src & ~32'h3;
        da = dst & ~32'h3;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({da, model[sa[11:2]]});
            exp_sum += model[sa[11:2]];
            model[da[11:2]] = model[sa[11:2]];
            sa += 32'd4;
            da += 32'd4;
        end
    endtask

    task automatic start_xfer(input logic [31:0] src, input logic [31:0] dst, input int n,
                              input int push_n);
        @(negedge clk);
        src_addr = src; dst_addr = dst; len = LEN_W'(n); start = 1'b1;
        exp_sum = '0;
        push_copy(src, dst, push_n);
        @(posedge clk);
        #1 start = 1'b0;
        src_addr = $urandom; dst_addr = $urandom; len = LEN_W'($urandom);
    endtask

    task automatic watch(input int budget, output int busy_cnt, output int wr_cnt,
                         output int done_at, output int done_cnt);
        busy_cnt = 0; wr_cnt = 0; done_at = 0; done_cnt = 0;
        for (int k = 1; k <= budget; k++) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
            if (mem_write === 1'b1) wr_cnt++;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_at == 0) done_at = k;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic test_reset();
        #12;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_mem_write", 32'(mem_write), 32'd0);
        chk("reset_mem_address", mem_address, 32'd0);
        chk("reset_mem_write_data", mem_write_data, 32'd0);
`ifdef MEM_COPY_CHECKSUM_EN
        chk("reset_checksum", checksum, 32'd0);
`endif
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_copy4();
        int b, w, da, dc;
        preload(0, 32'h11111111); preload(1, 32'h22222222);
        preload(2, 32'h33333333); preload(3, 32'h44444444);
        start_xfer(32'h000, 32'h100, 4, 4);
        watch(12, b, w, da, dc);
        chk("copy4_busy_cycles", 32'(b), 32'd8);
        chk("copy4_writes", 32'(w), 32'd4);
        chk("copy4_done_cycle", 32'(da), 32'd9);
        chk("copy4_done_pulses", 32'(dc), 32'd1);
        chk("copy4_mem0", mem[10'h40], 32'h11111111);
        chk("copy4_mem3", mem[10'h43], 32'h44444444);
        chk("copy4_queue_empty", 32'(exp_q.size()), 32'd0);
`ifdef MEM_COPY_CHECKSUM_EN
        chk("copy4_checksum", checksum, 32'hAAAAAAAA);
`endif
    endtask

    task automatic test_zero_len();
        int b, w, da, dc;
        start_xfer(32'h040, 32'h080, 0, 0);
        watch(4, b, w, da, dc);
        chk("zero_busy_cycles", 32'(b), 32'd0);
        chk("zero_writes", 32'(w), 32'd0);
        chk("zero_done_cycle", 32'(da), 32'd1);
        chk("zero_done_pulses", 32'(dc), 32'd1);
    endtask

    task automatic test_unaligned();
        int b, w, da, dc;
        preload(0, 32'h5A5A0001);
        start_xfer(32'h003, 32'h202, 1, 1);
        @(negedge clk);
        chk("unal_read_addr", mem_address, 32'h000);
        chk("unal_read_nowrite", 32'(mem_write), 32'd0);
        @(negedge clk);
        chk("unal_write_addr", mem_address, 32'h200);
        watch(3, b, w, da, dc);
        chk("unal_done_pulses", 32'(dc), 32'd1);
        chk("unal_mem", mem[10'h80], 32'h5A5A0001);
    endtask

    task automatic test_reset_mid();
        int b, w, da, dc, seen;
        for (int i = 0; i < 8; i++) begin
            preload(16 + i, 32'hC0DE0000 + 32'(i));
            preload(192 + i, 32'hDEAD0000 + 32'(i));
        end
        start_xfer(32'h040, 32'h300, 8, 2);
        seen = 0;
        for (int k = 0; k < 10 && seen < 2; k++) begin
            @(negedge clk);
            if (mem_write === 1'b1) seen++;
        end
        chk("rmid_two_writes_seen", 32'(seen), 32'd2);
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("rmid_third_write_live", {mem_address[30:0], mem_write}, {31'h308, 1'b1});
        reset = 1'b1;
        #1;
        chk("rmid_write_drops", 32'(mem_write), 32'd0);
        chk("rmid_busy_drops", 32'(busy), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        watch(4, b, w, da, dc);
        chk("rmid_no_done", 32'(dc), 32'd0);
        chk("rmid_no_busy", 32'(b), 32'd0);
        chk("rmid_word1", mem[193], 32'hC0DE0001);
        chk("rmid_word2_untouched", mem[194], 32'hDEAD0002);
        chk("rmid_queue_empty", 32'(exp_q.size()), 32'd0);
        start_xfer(32'h040, 32'h300, 3, 3);
        watch(10, b, w, da, dc);
        chk("rmid_again_done_cycle", 32'(da), 32'd7);
        chk("rmid_again_writes", 32'(w), 32'd3);
        chk("rmid_again_word2", mem[194], 32'hC0DE0002);
    endtask

    task automatic test_start_busy();
        int found;
        for (int i = 0; i < 4; i++) preload(32 + i, 32'hB0B00000 + 32'(i));
        start_xfer(32'h080, 32'h380, 4, 4);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            start = 1'b1; src_addr = 32'h000; dst_addr = 32'h3C0; len = LEN_W'(2);
        end
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int k = 0; k < 12 && found == 0; k++) begin
            @(negedge clk);
            if (done === 1'b1) found = 1;
        end
        chk("busy_done_seen", 32'(found), 32'd1);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("busy_start_in_done_ignored", 32'(busy), 32'd0);
        chk("busy_orig_word0", mem[224], 32'hB0B00000);
        chk("busy_orig_word3", mem[227], 32'hB0B00003);
        chk("busy_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic test_wrap_overlap();
        int b, w, da, dc;
        preload(1022, 32'hAAAA0001); preload(1023, 32'hAAAA0002); preload(0, 32'hAAAA0003);
        start_xfer(32'hFFFF_FFF8, 32'h3A0, 3, 3);
        watch(10, b, w, da, dc);
        chk("wrap_done_cycle", 32'(da), 32'd7);
        chk("wrap_word2", mem[10'hEA], 32'hAAAA0003);
        preload(384, 32'h0A0A0A0A); preload(385, 32'h0B0B0B0B);
        start_xfer(32'h600, 32'h604, 3, 3);
        watch(10, b, w, da, dc);
        chk("overlap_propagates", mem[387], 32'h0A0A0A0A);
        chk("overlap_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

`ifdef MEM_COPY_CHECKSUM_EN
    task automatic test_checksum();
        int b, w, da, dc;
        preload(0, 32'h11111111); preload(1, 32'h22222222);
        preload(2, 32'h33333333); preload(3, 32'h44444444);
        start_xfer(32'h000, 32'h140, 4, 4);
        watch(12, b, w, da, dc);
        chk("csum_first", checksum, 32'hAAAAAAAA);
        start_xfer(32'h000, 32'h180, 2, 2);
        chk("csum_cleared", checksum, 32'd0);
        watch(8, b, w, da, dc);
        chk("csum_second", checksum, exp_sum);
        chk("csum_second_const", checksum, 32'h33333333);
    endtask
`endif

    initial begin
        reset = 1'b1; start = 1'b0; pre_we = 1'b0; pre_idx = '0; pre_data = '0;
        src_addr = '0; dst_addr = '0; len = '0; exp_sum = '0;
        test_reset();
        test_copy4();
        test_zero_len();
        test_unaligned();
        test_reset_mid();
        test_start_busy();
        test_wrap_overlap();
`ifdef MEM_COPY_CHECKSUM_EN
        test_checksum();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_copy_engine.md
Name: mem_copy_engine

Overview:
- Bus-initiator block that drives the word-addressed, single-port data memory interface: combinational read data, write committed on the clock edge.
- Copies a block of N 32-bit words from a source region to a destination region.
- Used for program/data staging and test setup without CPU involvement.
- Shares the memory port via a top-level mux; the CPU side is held off while busy is high.

Parameters:
- LEN_W, 11, width of the word-count input; max transfer is 2^LEN_W-1 words; default covers a 1024-word memory.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- src_addr  input  32  source byte address; bits [1:0] ignored.
- dst_addr  input  32  destination byte address; bits [1:0] ignored.
- len  input  LEN_W  number of words to copy.
- busy  output  1  high in READ and WRITE states.
- done  output  1  one-cycle completion pulse.
- mem_write  output  1  write strobe to memory.
- mem_address  output  32  memory byte address; bits [1:0] always 0.
- mem_write_data  output  32  data to memory.
- mem_read_data  input  32  combinational read data from memory.

Behaviour:
- Reset is asynchronous and active-high; clk is the single clock.
- Reset forces: state=IDLE, busy=0, done=0, mem_write=0, mem_address=0, mem_write_data=0, and internal pointers, count and buffer to 0.
- Reset mid-transfer aborts immediately; no further writes occur and done is not pulsed.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - On an edge with start=1, latch src_ptr={src_addr[31:2],2'b00}, dst_ptr likewise, and remaining=len.
  - Go to DONE if len==0, else READ.
- READ:
  - mem_address=src_ptr, mem_write=0.
  - At the edge, latch mem_read_data into buf and go to WRITE.
- WRITE:
  - mem_address=dst_ptr, mem_write=1, mem_write_data=buf.
  - At the edge: src_ptr+=4, dst_ptr+=4, remaining-=1.
  - Go to DONE if remaining was 1, else READ.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE. start is ignored in DONE.
- Outputs outside READ/WRITE: mem_write=0, mem_address=0, mem_write_data=0.
- Latency: N words take 2N cycles in READ/WRITE plus 1 DONE cycle after the start edge. len=0 gives done on the cycle after start.
- start while busy or in DONE is ignored; there is no queueing.
- Pointer arithmetic is modulo 2^32; wrap past 0xFFFFFFFC continues at 0x00000000.
- Overlap: strictly forward, word by word.
  - dst<=src gives a correct copy.
  - dst>src with overlap propagates already-written words. This is defined behaviour, not an error.
- Input changes on src_addr/dst_addr/len after the start edge have no effect.

Optional Feature:
- Macro: MEM_COPY_CHECKSUM_EN.
- With it defined:
  - Adds output checksum[31:0], reset to 0.
  - Cleared to 0 at the start edge.
  - checksum += buf (mod 2^32) on each WRITE edge.
  - Holds its value after done until the next start.
- Without it: the port and accumulator are absent. All other behaviour is identical.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, READ=2'd1, WRITE=2'd2, DONE=2'd3) and WORD_BYTES=4.
- FSM, pointers and count stay in one module.
- The checksum accumulator is a natural sub-module, mem_copy_checksum: clk, reset, clear, enable, data in, sum out. It is instantiated only under MEM_COPY_CHECKSUM_EN.

Test Plan:
- Copy 4 words:
  - Stimulus: preload mem[0x000..0x00C]=0x11111111,0x22222222,0x33333333,0x44444444; start with src=0x000, dst=0x100, len=4.
  - Response: mem[0x100..0x10C] match the source; exactly 4 write strobes; done 9 cycles after the start edge; busy high for 8 cycles.
- Zero length:
  - Stimulus: len=0, src=0x040, dst=0x080.
  - Response: no mem_write; done on the cycle after start; busy never high.
- Unaligned addresses:
  - Stimulus: src=0x003, dst=0x202, len=1.
  - Response: reads 0x000, writes 0x200; mem_address[1:0]=0 on every cycle.
- Reset mid-transfer:
  - Stimulus: start len=8; assert reset asynchronously during the third WRITE cycle.
  - Response: mem_write drops within the same cycle; exactly 2 words written; done never pulses.
  - Follow-up: a new start after reset completes normally.
- start while busy:
  - Stimulus: pulse start with different args mid-transfer.
  - Response: ignored; original transfer completes with the original addresses.
- Checksum (MEM_COPY_CHECKSUM_EN):
  - Stimulus: the 4-word case above.
  - Response: checksum=0xAAAAAAAA after done.
  - Follow-up: a second start clears it to 0 before accumulating again.
